// File: rtl/cam_pkg.sv
// Shared camera-path definitions.
// Used by the capture, control_RAM and mask stages.
package cam_pkg;

  localparam int CAM_WIDTH  = 320;
  localparam int CAM_HEIGHT = 240;
  localparam int COL_W      = 9;
  localparam int ROW_W      = 8;

  typedef enum logic [1:0] {
    WAIT_VS_HIGH,
    WAIT_VS_LOW,
    ACTIVE
  } cap_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a third stage
// for rise/fall detection in the clk domain.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Synchronizer chain plus edge-history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 parallel-bus capture: keeps the Y byte
// of each pair and tags it with col/row/markers.
module ov7670_capture
  import cam_pkg::*;
#(
  parameter int WIDTH   = CAM_WIDTH,
  parameter int HEIGHT  = CAM_HEIGHT,
  parameter bit Y_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCLK,
  input  logic             Href,
  input  logic             VSYNC,
  input  logic [7:0]       in_pixel,
  output logic             pix_valid,
  output logic [7:0]       pix_y,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic             line_err
);

  localparam logic [COL_W-1:0] W_L = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0] H_L = ROW_W'(HEIGHT);
  localparam logic Y_PH = ~Y_FIRST;

  logic pclk_lvl, pclk_rise, pclk_fall;
  logic href_lvl, href_rise, href_fall;
  logic vs_lvl, vs_rise, vs_fall;
  logic unused_pclk;
  logic [7:0] d1, d2;

  sync_edge u_pclk (
    .clk(clk), .rst(rst), .din(PCLK),
    .level(pclk_lvl), .rise(pclk_rise),
    .fall(pclk_fall)
  );

  sync_edge u_href (
    .clk(clk), .rst(rst), .din(Href),
    .level(href_lvl), .rise(href_rise),
    .fall(href_fall)
  );

  sync_edge u_vs (
    .clk(clk), .rst(rst), .din(VSYNC),
    .level(vs_lvl), .rise(vs_rise),
    .fall(vs_fall)
  );

  assign unused_pclk = pclk_lvl ^ pclk_fall;

  // Data bus rides the same 2-flop depth as PCLK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= '0;
      d2 <= '0;
    end else begin
      d1 <= in_pixel;
      d2 <= d1;
    end
  end

  cap_state_t state, state_nx;
  logic [COL_W-1:0] col_cnt, col_eff;
  logic [ROW_W-1:0] row_cnt;
  logic phase, ph_eff, in_line, sof_arm;
  logic active, vs_end, line_start, line_ok;
  logic y_ev, take, over, line_end, err_set;

  // Frame-level FSM register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_VS_HIGH;
    else     state <= state_nx;
  end

  // Next state: only start after a full VSYNC pulse
  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_VS_HIGH: if (vs_lvl)  state_nx = WAIT_VS_LOW;
      WAIT_VS_LOW:  if (vs_fall) state_nx = ACTIVE;
      ACTIVE:       if (vs_rise) state_nx = WAIT_VS_LOW;
      default:      state_nx = WAIT_VS_HIGH;
    endcase
  end

  // Event decode: Href/VSYNC edges win over PCLK
  always_comb begin
    active     = (state == ACTIVE);
    vs_end     = active & vs_rise;
    line_start = active & href_rise & ~vs_rise;
    line_ok    = line_start ? (row_cnt < H_L) : in_line;
    col_eff    = line_start ? '0 : col_cnt;
    ph_eff     = href_rise ? 1'b0 : phase;
    y_ev       = active & ~vs_rise & pclk_rise
               & href_lvl & line_ok & (ph_eff == Y_PH);
    take       = y_ev & (col_eff < W_L);
    over       = y_ev & ~take;
    line_end   = active & ~vs_rise & href_fall & in_line;
    err_set    = over
               | (line_end & (col_cnt != W_L))
               | (line_start & (row_cnt >= H_L))
               | (vs_end & ((row_cnt != H_L)
                            | href_lvl | in_line));
  end

  // Counters, byte phase and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid <= 1'b0;
      pix_y     <= '0;
      col       <= '0;
      row       <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      line_err  <= 1'b0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      phase     <= 1'b0;
      in_line   <= 1'b0;
      sof_arm   <= 1'b0;
    end else begin
      pix_valid <= take;
      sof       <= take & sof_arm;
      eol       <= line_end;
      eof       <= vs_end;
      if (pclk_rise && href_lvl) phase <= ~ph_eff;
      else if (href_rise)        phase <= 1'b0;
      if (line_start) begin
        col_cnt <= '0;
        in_line <= (row_cnt < H_L);
      end
      if (take) begin
        col_cnt <= col_eff + COL_W'(1);
        pix_y   <= d2;
        col     <= col_eff;
        row     <= row_cnt;
        sof_arm <= 1'b0;
      end
      if (line_end) begin
        in_line <= 1'b0;
        row_cnt <= row_cnt + ROW_W'(1);
      end
      if (vs_end) in_line <= 1'b0;
      if (state == WAIT_VS_LOW && vs_fall) begin
        row_cnt <= '0;
        sof_arm <= 1'b1;
        in_line <= 1'b0;
      end
      if (err_set)             line_err <= 1'b1;
      else if (take && sof_arm) line_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture with a
// small 4x2 frame geometry, YUYV and UYVY.
module tb_ov7670_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic PCLK = 1'b0;
  logic Href = 1'b0;
  logic VSYNC = 1'b0;
  logic [7:0] in_pixel = 8'd0;

  logic a_pv, a_sof, a_eol, a_eof, a_err;
  logic [7:0] a_y, a_row;
  logic [8:0] a_col;
  logic b_pv, b_sof, b_eol, b_eof, b_err;
  logic [7:0] b_y, b_row;
  logic [8:0] b_col;

  always #5 clk = ~clk;

  ov7670_capture #(.WIDTH(4), .HEIGHT(2), .Y_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .PCLK(PCLK), .Href(Href),
    .VSYNC(VSYNC), .in_pixel(in_pixel),
    .pix_valid(a_pv), .pix_y(a_y), .col(a_col),
    .row(a_row), .sof(a_sof), .eol(a_eol),
    .eof(a_eof), .line_err(a_err)
  );

  ov7670_capture #(.WIDTH(4), .HEIGHT(2), .Y_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .PCLK(PCLK), .Href(Href),
    .VSYNC(VSYNC), .in_pixel(in_pixel),
    .pix_valid(b_pv), .pix_y(b_y), .col(b_col),
    .row(b_row), .sof(b_sof), .eol(b_eol),
    .eof(b_eof), .line_err(b_err)
  );

  int checks = 0;
  int errors = 0;
  int pv_n = 0, pvb_n = 0;
  int sof_n = 0, eol_n = 0, eof_n = 0;
  int sofb_n = 0, eolb_n = 0, eofb_n = 0;
  int max_col = 0;
  logic [7:0] ya [64];
  logic [8:0] ca [64];
  logic [7:0] ra [64];
  logic       sa [64];
  logic [7:0] yb [64];
  logic [8:0] cb [64];
  logic [7:0] rb [64];

  typedef struct {
    logic [7:0] ya;
    logic [8:0] col;
    logic [7:0] row;
    logic       sof;
    logic [7:0] yb;
  } vec_t;

  vec_t tbl [8];

  always @(negedge clk) begin
    if (a_pv) begin
      if (pv_n < 64) begin
        ya[pv_n] = a_y;
        ca[pv_n] = a_col;
        ra[pv_n] = a_row;
        sa[pv_n] = a_sof;
      end
      if (int'(a_col) > max_col) max_col = int'(a_col);
      pv_n++;
    end
    if (b_pv) begin
      if (pvb_n < 64) begin
        yb[pvb_n] = b_y;
        cb[pvb_n] = b_col;
        rb[pvb_n] = b_row;
      end
      pvb_n++;
    end
    if (a_sof) sof_n++;
    if (a_eol) eol_n++;
    if (a_eof) eof_n++;
    if (b_sof) sofb_n++;
    if (b_eol) eolb_n++;
    if (b_eof) eofb_n++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    pv_n = 0; pvb_n = 0; max_col = 0;
    sof_n = 0; eol_n = 0; eof_n = 0;
    sofb_n = 0; eolb_n = 0; eofb_n = 0;
  endtask

  task automatic put_byte(input logic [7:0] b, input bit lat);
    in_pixel = b;
    repeat (4) @(posedge clk);
    #1 PCLK = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      if (lat) begin
        @(negedge clk);
        if (k == 1) chk("latency_pv_low", int'(a_pv), 0);
        if (k == 2) chk("latency_pv_high", int'(a_pv), 1);
      end
    end
    #1 PCLK = 1'b0;
  endtask

  task automatic href_up();
    @(posedge clk);
    #1 Href = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic href_dn();
    repeat (4) @(posedge clk);
    #1 Href = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic send_line(input int ny, input bit lat);
    href_up();
    for (int i = 0; i < ny; i++) begin
      put_byte(8'(10 + i), lat && (i == 0));
      put_byte(8'(80 + i), 1'b0);
    end
    href_dn();
  endtask

  task automatic vs_set(input logic v);
    @(posedge clk);
    #1 VSYNC = v;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    tbl[0] = '{8'd10, 9'd0, 8'd0, 1'b1, 8'd80};
    tbl[1] = '{8'd11, 9'd1, 8'd0, 1'b0, 8'd81};
    tbl[2] = '{8'd12, 9'd2, 8'd0, 1'b0, 8'd82};
    tbl[3] = '{8'd13, 9'd3, 8'd0, 1'b0, 8'd83};
    tbl[4] = '{8'd10, 9'd0, 8'd1, 1'b0, 8'd80};
    tbl[5] = '{8'd11, 9'd1, 8'd1, 1'b0, 8'd81};
    tbl[6] = '{8'd12, 9'd2, 8'd1, 1'b0, 8'd82};
    tbl[7] = '{8'd13, 9'd3, 8'd1, 1'b0, 8'd83};

    #22;
    chk("reset_outputs",
        int'({a_pv, a_y, a_col, a_row, a_sof,
              a_eol, a_eof, a_err}), 0);
    #10 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Nominal frame
    vs_set(1'b1);
    clear_log();
    vs_set(1'b0);
    send_line(4, 1'b1);
    send_line(4, 1'b0);
    vs_set(1'b1);
    chk("nom_pv_count", pv_n, 8);
    chk("nom_sof_count", sof_n, 1);
    chk("nom_eol_count", eol_n, 2);
    chk("nom_eof_count", eof_n, 1);
    chk("nom_line_err", int'(a_err), 0);
    chk("uyvy_pv_count", pvb_n, 8);
    chk("uyvy_eol_count", eolb_n, 2);
    chk("uyvy_eof_count", eofb_n, 1);
    chk("uyvy_sof_count", sofb_n, 1);
    chk("uyvy_line_err", int'(b_err), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("nom_y[%0d]", i), int'(ya[i]), int'(tbl[i].ya));
      chk($sformatf("nom_col[%0d]", i), int'(ca[i]), int'(tbl[i].col));
      chk($sformatf("nom_row[%0d]", i), int'(ra[i]), int'(tbl[i].row));
      chk($sformatf("nom_sof[%0d]", i), int'(sa[i]), int'(tbl[i].sof));
      chk($sformatf("uyvy_y[%0d]", i), int'(yb[i]), int'(tbl[i].yb));
      chk($sformatf("uyvy_pos[%0d]", i),
          int'({cb[i], rb[i]}), int'({tbl[i].col, tbl[i].row}));
    end

    // Short line, then a correct frame clears the error
    clear_log();
    vs_set(1'b0);
    send_line(3, 1'b0);
    chk("short_eol", eol_n, 1);
    chk("short_err_set", int'(a_err), 1);
    send_line(4, 1'b0);
    vs_set(1'b1);
    chk("short_pv_count", pv_n, 7);
    chk("short_eof", eof_n, 1);
    clear_log();
    vs_set(1'b0);
    send_line(4, 1'b0);
    chk("short_err_cleared", int'(a_err), 0);
    send_line(4, 1'b0);
    vs_set(1'b1);
    chk("recover_pv_count", pv_n, 8);
    chk("recover_line_err", int'(a_err), 0);

    // Long line plus an extra third line
    clear_log();
    vs_set(1'b0);
    send_line(6, 1'b0);
    chk("long_err_set", int'(a_err), 1);
    chk("long_pv_first", pv_n, 4);
    send_line(4, 1'b0);
    send_line(4, 1'b0);
    vs_set(1'b1);
    chk("long_pv_count", pv_n, 8);
    chk("long_max_col", max_col, 3);
    chk("long_eol_count", eol_n, 2);
    chk("long_eof_count", eof_n, 1);
    chk("long_line_err", int'(a_err), 1);
    chk("long_hold_pos", int'({a_col, a_row}), int'({9'd3, 8'd1}));

    // VSYNC rises in the middle of a line
    clear_log();
    vs_set(1'b0);
    send_line(4, 1'b0);
    href_up();
    put_byte(8'd10, 1'b0);
    put_byte(8'd80, 1'b0);
    put_byte(8'd11, 1'b0);
    put_byte(8'd81, 1'b0);
    vs_set(1'b1);
    put_byte(8'd12, 1'b0);
    put_byte(8'd82, 1'b0);
    href_dn();
    chk("midvs_pv_count", pv_n, 6);
    chk("midvs_eol_count", eol_n, 1);
    chk("midvs_eof_count", eof_n, 1);
    chk("midvs_line_err", int'(a_err), 1);

    // Reset mid-frame, released with VSYNC low
    vs_set(1'b0);
    href_up();
    put_byte(8'd10, 1'b0);
    put_byte(8'd80, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("midrst_outputs",
        int'({a_pv, a_y, a_col, a_row, a_sof,
              a_eol, a_eof, a_err}), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_log();
    put_byte(8'd11, 1'b0);
    put_byte(8'd81, 1'b0);
    href_dn();
    send_line(4, 1'b0);
    chk("midrst_silent_pv", pv_n, 0);
    chk("midrst_silent_eol", eol_n, 0);
    vs_set(1'b1);
    chk("midrst_no_eof", eof_n, 0);
    vs_set(1'b0);
    send_line(4, 1'b0);
    send_line(4, 1'b0);
    vs_set(1'b1);
    chk("midrst_pv_count", pv_n, 8);
    chk("midrst_first_sof", int'(sa[0]), 1);
    chk("midrst_first_pos", int'({ca[0], ra[0]}), 0);
    chk("midrst_eof", eof_n, 1);
    chk("midrst_line_err", int'(a_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
